// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX stage bundle: decode-side fields in, registered EX-side fields and stall out.
// master drives decode fields and stage controls; slave is the pipeline register.
interface id_ex_pipe_reg_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [31:0]       id_instr;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_stall;
    logic              flush;

    logic              id_stall;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   ex_imm;
    logic [31:0]       ex_instr;
    logic [4:0]        ex_rd;
    logic [2:0]        ex_funct3;
    logic              ex_funct7b5;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_instr, id_ctrl,
        output ex_stall, flush,
        input  id_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_instr,
        input  ex_rd, ex_funct3, ex_funct7b5, ex_ctrl, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_instr, id_ctrl,
        input  ex_stall, flush,
        output id_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_instr,
        output ex_rd, ex_funct3, ex_funct7b5, ex_ctrl, bubble_cnt
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, branch flush and load-use bubble insertion.
// The interface instance must be built with the same XLEN/CTRL_W/CNT_W as this module.
module id_ex_pipe_reg #(
    parameter int          XLEN        = 32,
    parameter int          CTRL_W      = 8,
    parameter int          MEMREAD_BIT = 0,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic              CLK,
    input  logic              RST_n,
    id_ex_pipe_reg_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              r_ex_valid;
    logic [XLEN-1:0]   r_ex_pc;
    logic [XLEN-1:0]   r_ex_rs1_data;
    logic [XLEN-1:0]   r_ex_rs2_data;
    logic [XLEN-1:0]   r_ex_imm;
    logic [31:0]       r_ex_instr;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic [4:0]        w_ex_rd;
    logic              w_src_match;
    logic              w_hazard;

    assign w_ex_rd = r_ex_instr[11:7];

    // Both source fields are compared whatever the format; a false hit only costs a bubble.
    assign w_src_match = (w_ex_rd == bus.id_instr[19:15]) | (w_ex_rd == bus.id_instr[24:20]);
    assign w_hazard    = r_ex_valid & r_ex_ctrl[MEMREAD_BIT] & (w_ex_rd != 5'd0)
                       & bus.id_valid & w_src_match;

    assign bus.id_stall = ~bus.flush & (bus.ex_stall | w_hazard);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_instr    <= NOP_INSTR;
            r_ex_ctrl     <= '0;
            r_bubble_cnt  <= '0;
        end else if (bus.flush || (!bus.ex_stall && w_hazard)) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_instr    <= NOP_INSTR;
            r_ex_ctrl     <= '0;
            // Only a load-use bubble is counted; a flush leaves the counter alone.
            if (!bus.flush && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
        end else if (!bus.ex_stall) begin
            r_ex_valid    <= bus.id_valid;
            r_ex_pc       <= bus.id_pc;
            r_ex_rs1_data <= bus.id_rs1_data;
            r_ex_rs2_data <= bus.id_rs2_data;
            r_ex_imm      <= bus.id_imm;
            r_ex_instr    <= bus.id_instr;
            r_ex_ctrl     <= bus.id_valid ? bus.id_ctrl : '0;
        end
    end

    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_pc       = r_ex_pc;
    assign bus.ex_rs1_data = r_ex_rs1_data;
    assign bus.ex_rs2_data = r_ex_rs2_data;
    assign bus.ex_imm      = r_ex_imm;
    assign bus.ex_instr    = r_ex_instr;
    assign bus.ex_rd       = w_ex_rd;
    assign bus.ex_funct3   = r_ex_instr[14:12];
    assign bus.ex_funct7b5 = r_ex_instr[30];
    assign bus.ex_ctrl     = r_ex_ctrl;
    assign bus.bubble_cnt  = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Vector table for id_ex_pipe_reg with a queue of expected EX states; the
// bubble counter is narrowed to 2 bits so saturation is reachable.
module tb_id_ex_pipe_reg;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SUB  = 32'h4020_81B3; // sub x3,x1,x2
    localparam logic [31:0] ADD3 = 32'h0020_81B3; // add x3,x1,x2
    localparam logic [31:0] LW5  = 32'h0000_A283; // lw  x5,0(x1)
    localparam logic [31:0] ADD6 = 32'h0022_8333; // add x6,x5,x2
    localparam logic [31:0] LW0  = 32'h0000_A003; // lw  x0,0(x1)
    localparam logic [31:0] ADD7 = 32'h0000_03B3; // add x7,x0,x0
    localparam logic [31:0] ADD8 = 32'h0051_0433; // add x8,x2,x5
    localparam logic [7:0]  CA   = 8'h84;
    localparam logic [7:0]  CL   = 8'h21;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_pipe_reg_if #(.XLEN(32), .CTRL_W(8), .CNT_W(2)) bus ();
    id_ex_pipe_reg #(.XLEN(32), .CTRL_W(8), .MEMREAD_BIT(0), .CNT_W(2), .NOP_INSTR(NOP)) dut (
        .CLK(clk), .RST_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic v; logic [31:0] pc; logic [31:0] instr; logic [7:0] ctrl; logic st; logic fl;
        logic e_stall; logic e_v; logic [31:0] e_pc; logic [31:0] e_instr; logic [7:0] e_ctrl;
        logic [1:0] e_b;
    } vec_t;

    typedef struct {
        logic e_v; logic [31:0] e_pc; logic [31:0] e_instr; logic [7:0] e_ctrl; logic [1:0] e_b;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   row = 0;

    function automatic vec_t mk(logic v, logic [31:0] pc, logic [31:0] instr, logic [7:0] ctrl,
                                logic st, logic fl, logic e_stall, logic e_v, logic [31:0] e_pc,
                                logic [31:0] e_instr, logic [7:0] e_ctrl, logic [1:0] e_b);
        vec_t r;
        r.v = v; r.pc = pc; r.instr = instr; r.ctrl = ctrl; r.st = st; r.fl = fl;
        r.e_stall = e_stall; r.e_v = e_v; r.e_pc = e_pc; r.e_instr = e_instr;
        r.e_ctrl = e_ctrl; r.e_b = e_b;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (row %0d): got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [7:0] ctrl, input logic st, input logic fl);
        bus.id_valid    = v;
        bus.id_pc       = pc;
        bus.id_rs1_data = pc << 1;
        bus.id_rs2_data = pc << 2;
        bus.id_imm      = pc << 3;
        bus.id_instr    = instr;
        bus.id_ctrl     = ctrl;
        bus.ex_stall    = st;
        bus.flush       = fl;
    endtask

    // Data fields are driven as shifts of the PC, so expected data follows from expected PC.
    task automatic check_ex(input exp_t e);
        chk("ex_valid", 32'(bus.ex_valid), 32'(e.e_v));
        chk("ex_pc", bus.ex_pc, e.e_pc);
        chk("ex_rs1_data", bus.ex_rs1_data, e.e_pc << 1);
        chk("ex_rs2_data", bus.ex_rs2_data, e.e_pc << 2);
        chk("ex_imm", bus.ex_imm, e.e_pc << 3);
        chk("ex_instr", bus.ex_instr, e.e_instr);
        chk("ex_rd", 32'(bus.ex_rd), 32'(e.e_instr[11:7]));
        chk("ex_funct3", 32'(bus.ex_funct3), 32'(e.e_instr[14:12]));
        chk("ex_funct7b5", 32'(bus.ex_funct7b5), 32'(e.e_instr[30]));
        chk("ex_ctrl", 32'(bus.ex_ctrl), 32'(e.e_ctrl));
        chk("bubble_cnt", 32'(bus.bubble_cnt), 32'(e.e_b));
    endtask

    task automatic apply(input vec_t t);
        exp_t e;
        @(negedge clk);
        drive(t.v, t.pc, t.instr, t.ctrl, t.st, t.fl);
        #1;
        chk("id_stall", 32'(bus.id_stall), 32'(t.e_stall));
        e.e_v = t.e_v; e.e_pc = t.e_pc; e.e_instr = t.e_instr; e.e_ctrl = t.e_ctrl; e.e_b = t.e_b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty (row %0d): got 0 entries expected 1", row);
        end else begin
            check_ex(sb.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t rst_e;
        rst_e.e_v = 1'b0; rst_e.e_pc = '0; rst_e.e_instr = NOP; rst_e.e_ctrl = '0; rst_e.e_b = '0;

        //        v  pc      instr ctrl st fl | stall v  pc      instr ctrl b
        tbl.push_back(mk(1, 32'h00, SUB,  CA, 0, 0, 0, 1, 32'h00, SUB,  CA, 0));
        tbl.push_back(mk(1, 32'h04, ADD3, CA, 0, 0, 0, 1, 32'h04, ADD3, CA, 0));
        tbl.push_back(mk(1, 32'h08, SUB,  CA, 0, 0, 0, 1, 32'h08, SUB,  CA, 0));
        tbl.push_back(mk(1, 32'h0C, LW5,  CL, 0, 0, 0, 1, 32'h0C, LW5,  CL, 0));
        tbl.push_back(mk(1, 32'h10, ADD6, CA, 0, 0, 1, 0, 32'h00, NOP,  0,  1));
        tbl.push_back(mk(1, 32'h10, ADD6, CA, 0, 0, 0, 1, 32'h10, ADD6, CA, 1));
        tbl.push_back(mk(1, 32'h14, LW0,  CL, 0, 0, 0, 1, 32'h14, LW0,  CL, 1));
        tbl.push_back(mk(1, 32'h18, ADD7, CA, 0, 0, 0, 1, 32'h18, ADD7, CA, 1));
        tbl.push_back(mk(1, 32'h1C, SUB,  CA, 1, 0, 1, 1, 32'h18, ADD7, CA, 1));
        tbl.push_back(mk(1, 32'h20, SUB,  CA, 1, 0, 1, 1, 32'h18, ADD7, CA, 1));
        tbl.push_back(mk(1, 32'h24, SUB,  CA, 1, 0, 1, 1, 32'h18, ADD7, CA, 1));
        tbl.push_back(mk(1, 32'h24, SUB,  CA, 0, 0, 0, 1, 32'h24, SUB,  CA, 1));
        tbl.push_back(mk(1, 32'h28, LW5,  CL, 0, 0, 0, 1, 32'h28, LW5,  CL, 1));
        tbl.push_back(mk(1, 32'h2C, ADD6, CA, 0, 1, 0, 0, 32'h00, NOP,  0,  1));
        tbl.push_back(mk(1, 32'h30, SUB,  CA, 0, 0, 0, 1, 32'h30, SUB,  CA, 1));
        tbl.push_back(mk(1, 32'h34, SUB,  CA, 1, 1, 0, 0, 32'h00, NOP,  0,  1));
        tbl.push_back(mk(1, 32'h38, LW5,  CL, 0, 0, 0, 1, 32'h38, LW5,  CL, 1));
        tbl.push_back(mk(0, 32'h3C, ADD6, CA, 0, 0, 0, 0, 32'h3C, ADD6, 0,  1));
        tbl.push_back(mk(1, 32'h40, LW5,  CL, 0, 0, 0, 1, 32'h40, LW5,  CL, 1));
        tbl.push_back(mk(1, 32'h44, ADD8, CA, 0, 0, 1, 0, 32'h00, NOP,  0,  2));
        tbl.push_back(mk(1, 32'h44, ADD8, CA, 0, 0, 0, 1, 32'h44, ADD8, CA, 2));
        tbl.push_back(mk(1, 32'h48, LW5,  CL, 0, 0, 0, 1, 32'h48, LW5,  CL, 2));
        tbl.push_back(mk(1, 32'h4C, ADD6, CA, 1, 0, 1, 1, 32'h48, LW5,  CL, 2));
        tbl.push_back(mk(1, 32'h4C, ADD6, CA, 0, 0, 1, 0, 32'h00, NOP,  0,  3));
        tbl.push_back(mk(1, 32'h4C, ADD6, CA, 0, 0, 0, 1, 32'h4C, ADD6, CA, 3));
        tbl.push_back(mk(1, 32'h50, LW5,  CL, 0, 0, 0, 1, 32'h50, LW5,  CL, 3));
        tbl.push_back(mk(1, 32'h54, ADD6, CA, 0, 0, 1, 0, 32'h00, NOP,  0,  3));
        tbl.push_back(mk(1, 32'h54, ADD6, CA, 0, 0, 0, 1, 32'h54, ADD6, CA, 3));
        tbl.push_back(mk(1, 32'h58, LW5,  CL, 0, 0, 0, 1, 32'h58, LW5,  CL, 3));
        tbl.push_back(mk(1, 32'h5C, ADD6, CA, 0, 0, 1, 0, 32'h00, NOP,  0,  3));
        tbl.push_back(mk(1, 32'h60, LW5,  CL, 0, 0, 0, 1, 32'h60, LW5,  CL, 3));

        drive(0, 32'h0, NOP, 8'h0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_ex(rst_e);
        chk("reset_id_stall", 32'(bus.id_stall), 32'd0);

        foreach (tbl[i]) begin
            row = i + 1;
            apply(tbl[i]);
        end

        // Async reset between edges with a live load-use hazard pending.
        row = 100;
        @(negedge clk);
        drive(1, 32'h64, ADD6, CA, 0, 0);
        #1;
        chk("pre_reset_id_stall", 32'(bus.id_stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_ex(rst_e);
        chk("async_reset_id_stall", 32'(bus.id_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        row = 101;
        apply(mk(1, 32'h68, SUB, CA, 0, 0, 0, 1, 32'h68, SUB, CA, 0));

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
